// File: rtl/dance_seq_if.sv
// Table write bus between the CPU register slot and the dance sequencer.
interface dance_seq_if #(
    parameter int IDX_W = 4
);
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [18:0]      wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/dance_seq.sv
// Choreography sequencer: steps a CPU-written move table on each frame tick and drives sprite x0/y0/ctrl.
// Define DANCE_SEQ_CLAMP_EN to clamp the origin on screen; otherwise positions wrap modulo 2048.
module dance_seq #(
    parameter int H_MAX    = 640,
    parameter int V_MAX    = 480,
    parameter int SPR_SIZE = 32,
    parameter int X_HOME   = 304,
    parameter int Y_HOME   = 224,
    parameter int IDX_W    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [10:0]      x,
    input  logic [10:0]      y,
    dance_seq_if.slave       wr,
    input  logic [IDX_W-1:0] last_idx,
    input  logic             loop,
    input  logic             start,
    input  logic             stop,
    output logic [10:0]      x0,
    output logic [10:0]      y0,
    output logic [4:0]       ctrl,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] move_idx
);
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t      state, state_next;
    logic [18:0] table_q [DEPTH];
    logic [18:0] entry;
    logic [10:0] x_d1;
    logic        frame_tick;
    logic [5:0]  frames_left;
    logic [3:0]  dx_r, dy_r;
    logic [10:0] x_next, y_next;
    logic        move_end, seq_end;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) x_d1 <= '0;
        else          x_d1 <= x;
    end

    assign frame_tick = (x == 11'd0) && (y == 11'd0) && (x_d1 != 11'd0);

    // NOTE: the move table is a small register file and is cleared by reset, not left undefined.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
        end else if (wr.wr_en) begin
            table_q[wr.wr_addr] <= wr.wr_data;
        end
    end

    assign entry    = table_q[move_idx];
    assign move_end = frame_tick && (frames_left == 6'd1);
    assign seq_end  = move_end && (move_idx == last_idx) && !loop;

`ifdef DANCE_SEQ_CLAMP_EN
    localparam logic [11:0] X_LIM = 12'(H_MAX - SPR_SIZE);
    localparam logic [11:0] Y_LIM = 12'(V_MAX - SPR_SIZE);
    logic [11:0] x_sum, y_sum;

    assign x_sum = {1'b0, x0} + {{8{dx_r[3]}}, dx_r};
    assign y_sum = {1'b0, y0} + {{8{dy_r[3]}}, dy_r};

    always_comb begin
        x_next = x_sum[10:0];
        y_next = y_sum[10:0];
        if (x_sum[11])          x_next = '0;
        else if (x_sum > X_LIM) x_next = X_LIM[10:0];
        if (y_sum[11])          y_next = '0;
        else if (y_sum > Y_LIM) y_next = Y_LIM[10:0];
    end
`else
    // Bit 11 of the 12-bit sum never reaches the output, so an 11-bit add is equivalent.
    assign x_next = x0 + {{7{dx_r[3]}}, dx_r};
    assign y_next = y0 + {{7{dy_r[3]}}, dy_r};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: if (start && !stop) state_next = S_LOAD;
            S_LOAD: state_next = stop ? S_IDLE : S_RUN;
            S_RUN: begin
                if (stop)          state_next = S_IDLE;
                else if (seq_end)  state_next = S_DONE;
                else if (move_end) state_next = S_LOAD;
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state == S_LOAD) || (state == S_RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x0          <= 11'(X_HOME);
            y0          <= 11'(Y_HOME);
            ctrl        <= '0;
            move_idx    <= '0;
            frames_left <= '0;
            dx_r        <= '0;
            dy_r        <= '0;
            done        <= 1'b0;
        end else begin
            done <= (state_next == S_DONE);
            unique case (state)
                S_IDLE: if (start && !stop) move_idx <= '0;
                S_LOAD: if (!stop) begin
                    ctrl        <= entry[12:8];
                    frames_left <= (entry[18:13] == 6'd0) ? 6'd1 : entry[18:13];
                    dy_r        <= entry[7:4];
                    dx_r        <= entry[3:0];
                end
                S_RUN: if (!stop && frame_tick) begin
                    x0          <= x_next;
                    y0          <= y_next;
                    frames_left <= frames_left - 6'd1;
                    // A lowered last_idx lets the index run on and wrap until it matches again.
                    if (move_end) begin
                        if (move_idx == last_idx) begin
                            if (loop) move_idx <= '0;
                        end else begin
                            move_idx <= move_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dance_seq.sv
// Directed bench for dance_seq: table-driven single-move vectors plus loop, stop, clamp and late-write sequences.
module tb_dance_seq;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] x, y;
    logic [3:0]  last_idx;
    logic        loop, start, stop;
    logic [10:0] x0, y0;
    logic [4:0]  ctrl;
    logic        busy, done;
    logic [3:0]  move_idx;

    int total = 0;
    int bad   = 0;
    int done_seen;

    dance_seq_if #(.IDX_W(4)) wr_bus ();

    dance_seq dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .x        (x),
        .y        (y),
        .wr       (wr_bus.slave),
        .last_idx (last_idx),
        .loop     (loop),
        .start    (start),
        .stop     (stop),
        .x0       (x0),
        .y0       (y0),
        .ctrl     (ctrl),
        .busy     (busy),
        .done     (done),
        .move_idx (move_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_seen++;

    typedef struct {
        logic [5:0]  dur;
        logic [4:0]  ctl;
        logic [3:0]  dy;
        logic [3:0]  dx;
        int          n_ticks;
        logic [10:0] exp_x;
        logic [10:0] exp_y;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] addr, input logic [18:0] data);
        wr_bus.wr_en   = 1'b1;
        wr_bus.wr_addr = addr;
        wr_bus.wr_data = data;
        @(negedge clk);
        wr_bus.wr_en = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Returns at the negedge two cycles after LOAD, with the FSM in RUN.
    task automatic start_seq();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    // One gap cycle (x nonzero), one tick cycle, returns just after the update edge.
    task automatic tick();
        x = 11'd1; y = 11'd5;
        @(negedge clk);
        x = 11'd0; y = 11'd0;
        @(negedge clk);
        x = 11'd1; y = 11'd5;
    endtask

    initial begin
        vecs[0] = '{6'd3, 5'h05, 4'hF, 4'h2, 3, 11'd310, 11'd221};
        vecs[1] = '{6'd0, 5'h1F, 4'h7, 4'h8, 1, 11'd296, 11'd231};
        vecs[2] = '{6'd2, 5'h0A, 4'h0, 4'hF, 2, 11'd302, 11'd224};
        vecs[3] = '{6'd4, 5'h11, 4'h8, 4'h7, 4, 11'd332, 11'd192};
        vecs[4] = '{6'd1, 5'h10, 4'h0, 4'h0, 1, 11'd304, 11'd224};

        reset_n = 1'b0;
        x = 11'd1; y = 11'd5;
        last_idx = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
        wr_bus.wr_en = 1'b0; wr_bus.wr_addr = '0; wr_bus.wr_data = '0;
        repeat (2) @(negedge clk);
        check("reset x0", x0, 304);
        check("reset y0", y0, 224);
        check("reset ctrl", ctrl, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset move_idx", move_idx, 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            wr(4'd0, {vecs[i].dur, vecs[i].ctl, vecs[i].dy, vecs[i].dx});
            last_idx = '0; loop = 1'b0;
            start_seq();
            check($sformatf("v%0d ctrl", i), ctrl, vecs[i].ctl);
            check($sformatf("v%0d busy", i), busy, 1);
            repeat (vecs[i].n_ticks) tick();
            check($sformatf("v%0d x0", i), x0, vecs[i].exp_x);
            check($sformatf("v%0d y0", i), y0, vecs[i].exp_y);
            check($sformatf("v%0d done pulse", i), done, 1);
            check($sformatf("v%0d busy end", i), busy, 0);
            @(negedge clk);
            check($sformatf("v%0d done low", i), done, 0);
            check($sformatf("v%0d x0 hold", i), x0, vecs[i].exp_x);
        end

        // Asynchronous reset in the middle of a run.
        do_reset();
        wr(4'd0, {6'd3, 5'h05, 4'hF, 4'h2});
        start_seq();
        tick();
        check("midrun x0", x0, 306);
        #2 reset_n = 1'b0;
        #1;
        check("async x0", x0, 304);
        check("async y0", y0, 224);
        check("async ctrl", ctrl, 0);
        check("async busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Two-entry loop: index alternates, position toggles, no done.
        do_reset();
        wr(4'd0, {6'd1, 5'h00, 4'h0, 4'h1});
        wr(4'd1, {6'd1, 5'h00, 4'h0, 4'hF});
        last_idx = 4'd1; loop = 1'b1;
        done_seen = 0;
        start_seq();
        check("loop idx start", move_idx, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("loop x0 %0d", i), x0, (i % 2 == 0) ? 305 : 304);
            check($sformatf("loop idx %0d", i), move_idx, (i % 2 == 0) ? 1 : 0);
        end
        check("loop no done", done_seen, 0);
        check("loop busy", busy, 1);

        // Stop in the same cycle as a frame tick.
        @(negedge clk);
        x = 11'd0; y = 11'd0; stop = 1'b1;
        @(negedge clk);
        stop = 1'b0; x = 11'd1; y = 11'd5;
        check("stop x0", x0, 304);
        check("stop busy", busy, 0);
        check("stop done", done, 0);
        @(negedge clk);
        check("stop no done", done_seen, 0);
        start_seq();
        check("restart idx", move_idx, 0);
        tick();
        check("restart x0", x0, 305);

        // Long move: clamps at the right edge, or wraps past 2047.
        do_reset();
        wr(4'd0, {6'd63, 5'h00, 4'h0, 4'h7});
        last_idx = 4'd0; loop = 1'b1;
        start_seq();
        repeat (63) tick();
`ifdef DANCE_SEQ_CLAMP_EN
        check("clamp x0 63", x0, 608);
`else
        check("wrap x0 63", x0, 745);
`endif
        repeat (197) tick();
`ifdef DANCE_SEQ_CLAMP_EN
        check("clamp x0 260", x0, 608);
`else
        check("wrap x0 260", x0, 76);
`endif
        check("long y0", y0, 224);

        // Entry 1 rewritten mid-run, then again during its own LOAD cycle.
        do_reset();
        wr(4'd0, {6'd2, 5'h00, 4'h0, 4'h1});
        wr(4'd1, {6'd1, 5'h00, 4'h0, 4'h1});
        last_idx = 4'd1; loop = 1'b0;
        start_seq();
        wr(4'd1, {6'd1, 5'h0A, 4'h0, 4'hD});
        tick();
        tick();
        check("late x0 entry0", x0, 306);
        check("late idx", move_idx, 1);
        wr(4'd1, {6'd1, 5'h1F, 4'h0, 4'h5});
        check("late ctrl", ctrl, 5'h0A);
        tick();
        check("late x0 entry1", x0, 303);
        check("late done", done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
